mem_stage_wb_reg: RTL and testbench

//   Memory-access stage plus MEM/WB pipeline register of the RISC-V core. Takes the EX/MEM

---
 rtl/mem_stage_wb_reg.sv | 167 ++++++++++++++++
 tb/tb_mem_stage_wb_reg.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_wb_reg.sv
// Memory-access stage and MEM/WB pipeline register.
// Performs byte/half/word loads and stores on a word-organised data memory,
// extends load data, and registers everything for the write-back stage.
module mem_stage_wb_reg #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_mem_valid,
  input  logic        ex_mem_memread,
  input  logic        ex_mem_memwrite,
  input  logic        ex_mem_memtoreg,
  input  logic        ex_mem_regwrite,
  input  logic [2:0]  ex_mem_funct3,
  input  logic [31:0] ex_mem_result,
  input  logic [31:0] ex_mem_output_data_2,
  input  logic [1:0]  ex_mem_FWD_RS2,
  input  logic [4:0]  ex_mem_rd,
  input  logic [31:0] wb_write_data,
  input  logic        stall,
  input  logic        flush,
  output logic        mem_wb_valid,
  output logic        mem_wb_regwrite,
  output logic        memtoreg,
  output logic [31:0] read_data,
  output logic [31:0] result,
  output logic [4:0]  mem_wb_rd,
  output logic        misaligned
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0] r_mem [DEPTH];

  logic [DEPTH_LOG2-1:0] w_idx;
  logic [1:0]            w_off;
  logic [31:0]           w_rd_word;
  logic [31:0]           w_sd;
  logic [31:0]           w_wr_word;
  logic [31:0]           w_load_data;
  logic                  w_is_half;
  logic                  w_is_word;
  logic                  w_misaligned;
  logic                  w_store_size_ok;
  logic                  w_we;
  logic                  w_unused_addr;

  logic        r_valid_p1;
  logic        r_regwrite_p1;
  logic        r_memtoreg_p1;
  logic [31:0] r_read_data_p1;
  logic [31:0] r_result_p1;
  logic [4:0]  r_rd_p1;
  logic        r_misaligned_p1;

  // Select the addressed lane of a word and extend it to 32 bits.
  function automatic logic [31:0] load_extend(input logic [2:0]  f3,
                                              input logic [31:0] word,
                                              input logic [1:0]  off);
    logic        [7:0]  b;
    logic        [15:0] h;
    logic signed [31:0] v;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  v = 32'(signed'(b));
      3'b001:  v = 32'(signed'(h));
      3'b010:  v = word;
      3'b100:  v = 32'(b);
      3'b101:  v = 32'(h);
      default: v = '0;
    endcase
    return v;
  endfunction

  // Merge store data into the old word according to the access size.
  function automatic logic [31:0] store_merge(input logic [2:0]  f3,
                                              input logic [31:0] old,
                                              input logic [31:0] sd,
                                              input logic [1:0]  off);
    logic [31:0] w;
    w = old;
    case (f3)
      3'b000:  w[{off, 3'b000} +: 8]     = sd[7:0];
      3'b001:  w[{off[1], 4'b0000} +: 16] = sd[15:0];
      3'b010:  w = sd;
      default: w = old;
    endcase
    return w;
  endfunction

  // Upper address bits beyond the memory depth wrap and are intentionally ignored.
  assign w_unused_addr = &ex_mem_result[31:DEPTH_LOG2+2];

  assign w_idx     = ex_mem_result[DEPTH_LOG2+1:2];
  assign w_off     = ex_mem_result[1:0];
  assign w_rd_word = r_mem[w_idx];

  // Store data comes from write-back only for the 01 forward code; 1x falls back to rs2.
  assign w_sd = (ex_mem_FWD_RS2 == 2'b01) ? wb_write_data : ex_mem_output_data_2;

  assign w_is_half = (ex_mem_funct3 == 3'b001) || (ex_mem_funct3 == 3'b101);
  assign w_is_word = (ex_mem_funct3 == 3'b010);

  assign w_misaligned = ex_mem_valid && (ex_mem_memread || ex_mem_memwrite) &&
                        ((w_is_half && w_off[0]) || (w_is_word && (w_off != 2'b00)));

  assign w_store_size_ok = (ex_mem_funct3 == 3'b000) || (ex_mem_funct3 == 3'b001) ||
                           (ex_mem_funct3 == 3'b010);

  assign w_we = ex_mem_valid && ex_mem_memwrite && !w_misaligned && !stall && !flush &&
                w_store_size_ok;

  assign w_wr_word = store_merge(ex_mem_funct3, w_rd_word, w_sd, w_off);

  assign w_load_data = (ex_mem_valid && ex_mem_memread && !w_misaligned) ?
                       load_extend(ex_mem_funct3, w_rd_word, w_off) : 32'h0;

  // Data memory write port; the array itself is never cleared, and a store
  // that coincides with reset is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst) begin
      if (w_we) begin
        r_mem[w_idx] <= w_wr_word;
      end
    end
  end

  // MEM/WB register: flush inserts a bubble, stall holds, otherwise capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_p1      <= 1'b0;
      r_regwrite_p1   <= 1'b0;
      r_memtoreg_p1   <= 1'b0;
      r_read_data_p1  <= 32'h0;
      r_result_p1     <= 32'h0;
      r_rd_p1         <= 5'd0;
      r_misaligned_p1 <= 1'b0;
    end else if (flush) begin
      r_valid_p1      <= 1'b0;
      r_regwrite_p1   <= 1'b0;
      r_memtoreg_p1   <= 1'b0;
      r_read_data_p1  <= 32'h0;
      r_result_p1     <= 32'h0;
      r_rd_p1         <= 5'd0;
      r_misaligned_p1 <= 1'b0;
    end else if (!stall) begin
      r_valid_p1      <= ex_mem_valid;
      r_regwrite_p1   <= ex_mem_regwrite && ex_mem_valid && !w_misaligned &&
                         (ex_mem_rd != 5'd0);
      r_memtoreg_p1   <= ex_mem_memtoreg;
      r_read_data_p1  <= w_load_data;
      r_result_p1     <= ex_mem_result;
      r_rd_p1         <= ex_mem_rd;
      r_misaligned_p1 <= w_misaligned;
    end
  end

  assign mem_wb_valid    = r_valid_p1;
  assign mem_wb_regwrite = r_regwrite_p1;
  assign memtoreg        = r_memtoreg_p1;
  assign read_data       = r_read_data_p1;
  assign result          = r_result_p1;
  assign mem_wb_rd       = r_rd_p1;
  assign misaligned      = r_misaligned_p1;

endmodule

// File: tb/tb_mem_stage_wb_reg.sv
// Bench for mem_stage_wb_reg: directed scenarios followed by random traffic,
// all checked against a byte-addressed reference model of the memory stage.
module tb_mem_stage_wb_reg;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_mem_valid, ex_mem_memread, ex_mem_memwrite, ex_mem_memtoreg, ex_mem_regwrite;
  logic [2:0]  ex_mem_funct3;
  logic [31:0] ex_mem_result, ex_mem_output_data_2, wb_write_data;
  logic [1:0]  ex_mem_FWD_RS2;
  logic [4:0]  ex_mem_rd;
  logic        stall, flush;
  logic        mem_wb_valid, mem_wb_regwrite, memtoreg, misaligned;
  logic [31:0] read_data, result;
  logic [4:0]  mem_wb_rd;

  mem_stage_wb_reg #(.DEPTH_LOG2(10)) dut (
    .clk(clk), .rst(rst),
    .ex_mem_valid(ex_mem_valid), .ex_mem_memread(ex_mem_memread),
    .ex_mem_memwrite(ex_mem_memwrite), .ex_mem_memtoreg(ex_mem_memtoreg),
    .ex_mem_regwrite(ex_mem_regwrite), .ex_mem_funct3(ex_mem_funct3),
    .ex_mem_result(ex_mem_result), .ex_mem_output_data_2(ex_mem_output_data_2),
    .ex_mem_FWD_RS2(ex_mem_FWD_RS2), .ex_mem_rd(ex_mem_rd),
    .wb_write_data(wb_write_data), .stall(stall), .flush(flush),
    .mem_wb_valid(mem_wb_valid), .mem_wb_regwrite(mem_wb_regwrite),
    .memtoreg(memtoreg), .read_data(read_data), .result(result),
    .mem_wb_rd(mem_wb_rd), .misaligned(misaligned)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: memory as a flat array of bytes (4 KiB = 1024 words).
  logic [7:0]  mb [4096];
  logic        e_valid, e_rw, e_m2r, e_mis;
  logic [31:0] e_rdata, e_res;
  logic [4:0]  e_rd;

  task automatic zero_exp();
    e_valid = 1'b0; e_rw = 1'b0; e_m2r = 1'b0; e_mis = 1'b0;
    e_rdata = 32'h0; e_res = 32'h0; e_rd = 5'd0;
  endtask

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    logic [31:0] a, sd;
    logic [11:0] b;
    bit          half, word, mis;
    longint      v;
    if (rst || flush) begin
      zero_exp();
      return;
    end
    if (stall) return;
    a    = ex_mem_result;
    b    = a[11:0];
    half = (ex_mem_funct3 == 3'd1) || (ex_mem_funct3 == 3'd5);
    word = (ex_mem_funct3 == 3'd2);
    mis  = ex_mem_valid && (ex_mem_memread || ex_mem_memwrite) &&
           ((half && (a % 2 != 0)) || (word && (a % 4 != 0)));
    sd   = (ex_mem_FWD_RS2 == 2'b01) ? wb_write_data : ex_mem_output_data_2;
    v = 0;
    if (ex_mem_valid && ex_mem_memread && !mis) begin
      case (ex_mem_funct3)
        3'd0: begin v = longint'(mb[b]); if (v >= 128) v = v - 256; end
        3'd1: begin
          v = longint'(mb[b]) + 256 * longint'(mb[b+1]);
          if (v >= 32768) v = v - 65536;
        end
        3'd2: v = longint'(mb[b]) + 256 * longint'(mb[b+1]) +
                  65536 * longint'(mb[b+2]) + 16777216 * longint'(mb[b+3]);
        3'd4: v = longint'(mb[b]);
        3'd5: v = longint'(mb[b]) + 256 * longint'(mb[b+1]);
        default: v = 0;
      endcase
    end
    if (ex_mem_valid && ex_mem_memwrite && !mis) begin
      case (ex_mem_funct3)
        3'd0: mb[b] = sd[7:0];
        3'd1: begin mb[b] = sd[7:0]; mb[b+1] = sd[15:8]; end
        3'd2: begin
          mb[b] = sd[7:0]; mb[b+1] = sd[15:8]; mb[b+2] = sd[23:16]; mb[b+3] = sd[31:24];
        end
        default: ;
      endcase
    end
    e_valid = ex_mem_valid;
    e_rw    = ex_mem_regwrite && ex_mem_valid && !mis && (ex_mem_rd != 5'd0);
    e_m2r   = ex_mem_memtoreg;
    e_rdata = v[31:0];
    e_res   = a;
    e_rd    = ex_mem_rd;
    e_mis   = mis;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".valid"},      32'(mem_wb_valid),    32'(e_valid));
    chk({tag, ".regwrite"},   32'(mem_wb_regwrite), 32'(e_rw));
    chk({tag, ".memtoreg"},   32'(memtoreg),        32'(e_m2r));
    chk({tag, ".read_data"},  read_data,            e_rdata);
    chk({tag, ".result"},     result,               e_res);
    chk({tag, ".rd"},         32'(mem_wb_rd),       32'(e_rd));
    chk({tag, ".misaligned"}, 32'(misaligned),      32'(e_mis));
  endtask

  // One clock: model the edge, let the DUT take it, then compare 1 time unit later.
  task automatic cyc(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Set up a valid load (ld=1) or store (ld=0) instruction.
  task automatic op(input bit ld, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] d);
    ex_mem_valid         = 1'b1;
    ex_mem_memread       = ld;
    ex_mem_memwrite      = !ld;
    ex_mem_memtoreg      = ld;
    ex_mem_regwrite      = ld;
    ex_mem_funct3        = f3;
    ex_mem_result        = a;
    ex_mem_output_data_2 = d;
    ex_mem_FWD_RS2       = 2'b00;
    ex_mem_rd            = 5'd7;
    wb_write_data        = $urandom;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
    ex_mem_valid = 1'b0; ex_mem_memread = 1'b0; ex_mem_memwrite = 1'b0;
    ex_mem_memtoreg = 1'b0; ex_mem_regwrite = 1'b0; ex_mem_funct3 = 3'd0;
    ex_mem_result = 32'h0; ex_mem_output_data_2 = 32'h0; ex_mem_FWD_RS2 = 2'b00;
    ex_mem_rd = 5'd0; wb_write_data = 32'h0;
    for (int i = 0; i < 4096; i++) mb[i] = 8'h00;

    // Reset state
    #2 rst = 1'b1;
    #1;
    zero_exp();
    check_all("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;

    // Give the 16 words used below known contents
    for (int w = 0; w < 16; w++) begin
      op(1'b0, 3'd2, 32'(w * 4), $urandom);
      cyc("init");
    end

    // 1: SW then LW of the same word
    op(1'b0, 3'd2, 32'h10, 32'hDEADBEEF); cyc("t1_sw");
    op(1'b1, 3'd2, 32'h10, 32'h0);        cyc("t1_lw");
    chk("t1_lw_data", read_data, 32'hDEADBEEF);
    chk("t1_lw_m2r", 32'(memtoreg), 32'd1);

    // 2: SB then signed / unsigned byte loads, then whole word
    op(1'b0, 3'd0, 32'h21, 32'hABCDEF80); cyc("t2_sb");
    op(1'b1, 3'd0, 32'h21, 32'h0);        cyc("t2_lb");
    chk("t2_lb_data", read_data, 32'hFFFFFF80);
    op(1'b1, 3'd4, 32'h21, 32'h0);        cyc("t2_lbu");
    chk("t2_lbu_data", read_data, 32'h00000080);
    op(1'b1, 3'd2, 32'h20, 32'h0);        cyc("t2_lw");

    // 3: store data forwarded from write-back
    op(1'b0, 3'd2, 32'h30, 32'h0);
    ex_mem_FWD_RS2 = 2'b01; wb_write_data = 32'h12345678;
    cyc("t3_sw_fwd");
    op(1'b1, 3'd2, 32'h30, 32'h0);        cyc("t3_lw");
    chk("t3_lw_data", read_data, 32'h12345678);

    // 4: misaligned load and store
    op(1'b1, 3'd1, 32'h03, 32'h0);        cyc("t4_lh_mis");
    chk("t4_mis", 32'(misaligned), 32'd1);
    chk("t4_rw", 32'(mem_wb_regwrite), 32'd0);
    chk("t4_rdata", read_data, 32'd0);
    op(1'b0, 3'd2, 32'h02, 32'hFFFFFFFF); cyc("t4_sw_mis");
    op(1'b1, 3'd2, 32'h00, 32'h0);        cyc("t4_lw0");

    // 5: stall holds and blocks the store; stall+flush gives a bubble
    op(1'b1, 3'd2, 32'h14, 32'h0);        cyc("t5_lw_a");
    stall = 1'b1;
    op(1'b0, 3'd2, 32'h14, 32'hCAFEF00D); cyc("t5_stall_sw");
    chk("t5_hold_res", result, 32'h14);
    stall = 1'b0;
    op(1'b1, 3'd2, 32'h14, 32'h0);        cyc("t5_lw_b");
    stall = 1'b1; flush = 1'b1;
    op(1'b0, 3'd2, 32'h14, 32'h0BADF00D); cyc("t5_flush_sw");
    chk("t5_bubble_valid", 32'(mem_wb_valid), 32'd0);
    stall = 1'b0; flush = 1'b0;
    op(1'b1, 3'd2, 32'h14, 32'h0);        cyc("t5_lw_c");

    // 6: reset in the middle of a pending store
    op(1'b1, 3'd2, 32'h10, 32'h0);        cyc("t6_lw_a");
    op(1'b0, 3'd2, 32'h18, 32'h55AA55AA);
    #2 rst = 1'b1;
    #1;
    zero_exp();
    check_all("t6_async");
    chk("t6_result0", result, 32'h0);
    cyc("t6_rst_edge");
    rst = 1'b0;
    op(1'b1, 3'd2, 32'h18, 32'h0);        cyc("t6_lw_old");

    // Random traffic over the initialised region, with wrapping upper address bits
    for (int i = 0; i < 400; i++) begin
      int k;
      k = int'($urandom_range(0, 2));
      ex_mem_valid         = ($urandom_range(0, 7) != 0);
      ex_mem_memread       = (k == 1);
      ex_mem_memwrite      = (k == 2);
      ex_mem_memtoreg      = 1'($urandom);
      ex_mem_regwrite      = 1'($urandom);
      ex_mem_funct3        = 3'($urandom_range(0, 7));
      ex_mem_result        = $urandom & 32'hFFFFF03F;
      ex_mem_output_data_2 = $urandom;
      ex_mem_FWD_RS2       = 2'($urandom_range(0, 3));
      ex_mem_rd            = 5'($urandom_range(0, 31));
      wb_write_data        = $urandom;
      stall                = ($urandom_range(0, 7) == 0);
      flush                = ($urandom_range(0, 9) == 0);
      cyc("rand");
    end
    stall = 1'b0; flush = 1'b0;

    // Read back every word of the region
    for (int w = 0; w < 16; w++) begin
      op(1'b1, 3'd2, 32'(w * 4), 32'h0);
      cyc("final_lw");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
